// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix ingest/egress datapaths: default widths
// and the egress FSM state encoding.
package matrix_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int ADDR_WIDTH_DEF = 1;

    typedef logic [1:0] egress_state_t;

    localparam egress_state_t ST_IDLE   = 2'd0;
    localparam egress_state_t ST_FETCH  = 2'd1;
    localparam egress_state_t ST_STREAM = 2'd2;
    localparam egress_state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/egress_ram.sv
// Simple dual-port buffer: one write port, one synchronous read port with
// 1-clk latency. The read register only updates when rd_en is high.
module egress_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/matrix_egress.sv
// Readout buffer for annealer result rows: loaded by the core, then streamed
// out over valid/ready at one word per clock on a start command.
module matrix_egress
    import matrix_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_drop
);

    localparam logic [ADDR_WIDTH:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    function automatic logic [ADDR_WIDTH:0] sat_len(input logic [ADDR_WIDTH:0] l);
        return (l > LEN_MAX) ? LEN_MAX : l;
    endfunction

    egress_state_t         state;
    logic [ADDR_WIDTH:0]   len_r;
    logic [ADDR_WIDTH-1:0] beat;
    logic                  fresh;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  done_r;
    logic                  wr_drop_r;

    logic                  busy_int;
    logic                  start_go;
    logic                  is_last;
    logic                  hs;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] rd_q;

    assign busy_int = (state == ST_FETCH) || (state == ST_STREAM);
    assign start_go = (state == ST_IDLE) && start && (len != '0);
    assign out_valid = (state == ST_STREAM);
    assign is_last  = ({1'b0, beat} == (len_r - 1'b1));
    assign hs       = out_valid && out_ready;

    // The next word is fetched on the accepting handshake so it is on the RAM
    // output exactly one cycle later, giving back-to-back beats.
    assign rd_en   = (state == ST_FETCH) || (hs && !is_last);
    assign rd_addr = (state == ST_FETCH) ? '0 : beat + 1'b1;
    // A write landing in the same cycle as an accepted start counts as busy-time.
    assign ram_we  = wr_en && !busy_int && !start_go;

    egress_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (ram_we),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_q)
    );

    // Fresh RAM data drives the output directly; during a stall the word is
    // parked in the skid register so it stays stable until accepted.
    assign out_data = fresh ? rd_q : data_r;
    assign out_last = out_valid && is_last;
    assign busy     = busy_int;
    assign done     = done_r;
    assign wr_drop  = wr_drop_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            len_r     <= '0;
            beat      <= '0;
            fresh     <= 1'b0;
            data_r    <= '0;
            done_r    <= 1'b0;
            wr_drop_r <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            wr_drop_r <= wr_en && (busy_int || start_go);
            fresh     <= rd_en;
            if (fresh) begin
                data_r <= rd_q;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            len_r <= sat_len(len);
                            beat  <= '0;
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (hs) begin
                        if (is_last) begin
                            state  <= ST_DONE;
                            done_r <= 1'b1;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
